pre_addr_source_scheduler: RTL

Sequential consumer of the per-state predecessor-address vector used in Viterbi traceback. It accepts one POS_num-bit vector per handshake, then serializes its set bits into one state index per output beat, lowest index first, so the single-port path-memory reader downstream handles one predecessor at a time. It also registers the multiple-source condition (more than one bit set) and the popcount, and holds both for the whole burst.

---
 rtl/viterbi_pkg.sv | 14 +
 rtl/pre_addr_lsb_encoder.sv | 40 ++++
 rtl/pre_addr_source_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi traceback definitions: default state-space sizes, scheduler FSM
// states and the width of the optional statistics counter.
package viterbi_pkg;

    localparam int POS_NUM_DEFAULT     = 11;
    localparam int POS_NUM_BIT_DEFAULT = 4;
    localparam int STAT_CNT_W          = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/pre_addr_lsb_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit, its one-hot
// mask, and a flag that the whole vector holds exactly one set bit.
module pre_addr_lsb_encoder #(
    parameter int POS_num     = 11,
    parameter int POS_num_bit = 4
) (
    input  logic [POS_num-1:0]     vec,
    output logic [POS_num_bit-1:0] lsb_idx,
    output logic [POS_num-1:0]     lsb_onehot,
    output logic                   is_onehot
);

    // seen[i] is high when any bit below position i is set
    logic [POS_num-1:0] seen;

    assign seen[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < POS_num; gi++) begin : g_seen
            assign seen[gi] = seen[gi-1] | vec[gi-1];
        end
        for (gi = 0; gi < POS_num; gi++) begin : g_first
            assign lsb_onehot[gi] = vec[gi] & ~seen[gi];
        end
    endgenerate

    always_comb begin
        lsb_idx = '0;
        for (int i = 0; i < POS_num; i++) begin
            if (lsb_onehot[i]) begin
                lsb_idx = lsb_idx | POS_num_bit'(i);
            end
        end
    end

    // Exactly one bit set: nonzero, and nothing remains once the lowest is removed
    assign is_onehot = (vec != '0) && ((vec & ~lsb_onehot) == '0);

endmodule

// File: rtl/pre_addr_source_scheduler.sv
// Serializes a predecessor-address vector into one source-state index per beat,
// lowest first. Optional macro PRE_ADDR_SCHED_STATS_EN adds stat_multi_cnt.
module pre_addr_source_scheduler
    import viterbi_pkg::*;
#(
    parameter int POS_num     = POS_NUM_DEFAULT,
    parameter int POS_num_bit = POS_NUM_BIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [POS_num-1:0]     pre_addr_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [POS_num_bit-1:0] out_idx,
    output logic                   out_last,
    output logic [POS_num_bit-1:0] src_count,
    output logic                   multiple_source,
    output logic                   empty_drop
`ifdef PRE_ADDR_SCHED_STATS_EN
    ,
    output logic [STAT_CNT_W-1:0]  stat_multi_cnt
`endif
);

    sched_state_t           state_reg;
    logic [POS_num-1:0]     pending_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic [POS_num_bit-1:0] src_count_reg;
    logic                   multiple_source_reg;
    logic                   empty_drop_reg;

    logic [POS_num_bit-1:0] lsb_idx;
    logic [POS_num-1:0]     lsb_onehot;
    logic                   lsb_is_last;
    logic [POS_num_bit-1:0] in_popcount;
    logic                   in_multi;
    logic                   accept;
    logic                   beat_done;

    pre_addr_lsb_encoder #(
        .POS_num     (POS_num),
        .POS_num_bit (POS_num_bit)
    ) u_lsb_encoder (
        .vec        (pending_reg),
        .lsb_idx    (lsb_idx),
        .lsb_onehot (lsb_onehot),
        .is_onehot  (lsb_is_last)
    );

    always_comb begin
        in_popcount = '0;
        for (int i = 0; i < POS_num; i++) begin
            in_popcount = in_popcount + POS_num_bit'(pre_addr_in[i]);
        end
    end

    assign in_multi  = (in_popcount >= POS_num_bit'(2));
    assign accept    = in_valid & in_ready_reg;
    assign beat_done = out_valid_reg & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= IDLE;
            pending_reg         <= '0;
            in_ready_reg        <= 1'b1;
            out_valid_reg       <= 1'b0;
            src_count_reg       <= '0;
            multiple_source_reg <= 1'b0;
            empty_drop_reg      <= 1'b0;
        end else begin
            empty_drop_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pending_reg         <= pre_addr_in;
                        src_count_reg       <= in_popcount;
                        multiple_source_reg <= in_multi;
                        if (pre_addr_in == '0) begin
                            empty_drop_reg <= 1'b1;
                        end else begin
                            state_reg     <= ISSUE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Retire the presented index; the encoder then offers the next-lowest one
                    if (beat_done) begin
                        pending_reg <= pending_reg & ~lsb_onehot;
                        if (lsb_is_last) begin
                            state_reg     <= IDLE;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef PRE_ADDR_SCHED_STATS_EN
    logic [STAT_CNT_W-1:0] stat_multi_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_multi_cnt_reg <= '0;
        end else if (accept && in_multi && (stat_multi_cnt_reg != '1)) begin
            stat_multi_cnt_reg <= stat_multi_cnt_reg + 1'b1;
        end
    end

    assign stat_multi_cnt = stat_multi_cnt_reg;
`endif

    // pending is empty outside ISSUE, so the encoder yields idx 0 / last 0 there
    assign in_ready        = in_ready_reg;
    assign out_valid       = out_valid_reg;
    assign out_idx         = lsb_idx;
    assign out_last        = lsb_is_last;
    assign src_count       = src_count_reg;
    assign multiple_source = multiple_source_reg;
    assign empty_drop      = empty_drop_reg;

endmodule
